// File: rtl/dds_wavegen.sv
// dds_wavegen: phase-accumulator DDS with sine/triangle/saw/square shapes,
// phase offset and binary attenuation; 8-bit offset-binary output.
module dds_wavegen #(
   parameter int PHASE_W   = 24,
   parameter bit SYNC_PRIO = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ena,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic [7:0]         phase_off,
   input  logic [1:0]         wave_sel,
   input  logic [1:0]         atten,
   input  logic               sync,
   output logic [7:0]         wave_out,
   output logic               out_valid,
   output logic               cycle_tick
);
   localparam logic [6:0] Q [65] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
      7'd127
   };
   logic [PHASE_W-1:0] acc_q, acc_d;
   logic [PHASE_W:0]   sum;
   logic               tick_q, tick_d, en0_q, en1_q, vld_q, do_sync;
   logic [7:0]         idx_q, idx_d, raw, out_q, out_d;
   logic [1:0]         sel_q, att_q;
   logic [6:0]         k, m;
   logic signed [8:0]  s, sh;
   always_comb begin
      do_sync = sync && (SYNC_PRIO || ena);
      sum     = {1'b0, acc_q} + {1'b0, freq_word};
      acc_d   = do_sync ? '0 : ena ? sum[PHASE_W-1:0] : acc_q;
      tick_d  = !do_sync && ena && sum[PHASE_W];
      idx_d   = acc_q[PHASE_W-1 -: 8] + phase_off;
      k       = idx_q[6:0];
      // second quadrant mirrors the quarter table; the sign comes from idx[7]
      m       = (k > 7'd64) ? 7'd0 - k : k;
      raw     = (sel_q == 2'd0) ? (idx_q[7] ? 8'd128 - {1'b0, Q[m]} : 8'd128 + {1'b0, Q[m]}) :
                (sel_q == 2'd1) ? (idx_q[7] ? ~{k, 1'b0} : {k, 1'b0}) :
                (sel_q == 2'd2) ? idx_q : {8{~idx_q[7]}};
      s       = $signed({1'b0, raw}) - 9'sd128;
      sh      = s >>> att_q;
      out_d   = 8'(sh + 9'sd128);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
         en0_q  <= 1'b0;
         en1_q  <= 1'b0;
         idx_q  <= '0;
         sel_q  <= '0;
         att_q  <= '0;
         out_q  <= 8'h80;
         vld_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
         en0_q  <= ena;
         en1_q  <= en0_q;
         idx_q  <= idx_d;
         sel_q  <= wave_sel;
         att_q  <= atten;
         out_q  <= out_d;
         vld_q  <= en1_q;
      end
   end
   assign wave_out   = out_q;
   assign out_valid  = vld_q;
   assign cycle_tick = tick_q;
endmodule

// File: tb/tb_dds_wavegen.sv
// tb_dds_wavegen: directed checks of the DDS generator at PHASE_W=16, one index step per enabled cycle.
module tb_dds_wavegen;
   localparam int PW = 16;
   logic          clk = 1'b0, reset = 1'b1, ena = 1'b0, sync = 1'b0;
   logic [PW-1:0] freq_word = 16'h0100;
   logic [7:0]    phase_off = 8'd0;
   logic [1:0]    wave_sel = 2'd0, atten = 2'd0;
   logic [7:0]    wave_out;
   logic          out_valid, cycle_tick;
   int            vecs = 0, errs = 0, cyc = 0, ticks = 0, last_tick = -1;

   always #5 clk = ~clk;

   dds_wavegen #(.PHASE_W(PW), .SYNC_PRIO(1'b1)) dut (
      .clk(clk), .reset(reset), .ena(ena), .freq_word(freq_word),
      .phase_off(phase_off), .wave_sel(wave_sel), .atten(atten), .sync(sync),
      .wave_out(wave_out), .out_valid(out_valid), .cycle_tick(cycle_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cycle_tick === 1'b1) begin
            ticks++;
            last_tick = cyc;
         end
      end
   endtask

   task automatic sample(input int t, input logic [1:0] sel, input logic [1:0] att,
                         input logic [7:0] exp, input string tag);
      goto(t - 2);
      wave_sel = sel;
      atten    = att;
      goto(t);
      chk(tag, {24'd0, wave_out}, {24'd0, exp});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wave", {24'd0, wave_out}, 32'h80);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_tick", {31'd0, cycle_tick}, 32'd0);
      reset = 1'b0;
      ena   = 1'b1;
      cyc   = 0;
      goto(2);    chk("sine_i0", {24'd0, wave_out}, 32'd128);
                  chk("valid_c2", {31'd0, out_valid}, 32'd0);
      goto(3);    chk("sine_i1", {24'd0, wave_out}, 32'd131);
                  chk("valid_c3", {31'd0, out_valid}, 32'd1);
      goto(4);    chk("sine_i2", {24'd0, wave_out}, 32'd134);
      goto(34);   chk("sine_i32", {24'd0, wave_out}, 32'd218);
      goto(66);   chk("sine_i64", {24'd0, wave_out}, 32'd255);
      goto(130);  chk("sine_i128", {24'd0, wave_out}, 32'd128);
      goto(194);  chk("sine_i192", {24'd0, wave_out}, 32'd1);
      goto(258);  chk("tick_cnt1", ticks, 32'd1);
                  chk("tick_at1", last_tick, 32'd256);
      goto(513);  chk("tick_cnt2", ticks, 32'd2);
                  chk("tick_at2", last_tick, 32'd512);
      goto(576);
      wave_sel = 2'd1;
      goto(577);  chk("sel_old_sine63", {24'd0, wave_out}, 32'd255);
      goto(578);  chk("tri_i64", {24'd0, wave_out}, 32'd128);
      sample(714, 2'd1, 2'd0, 8'd111, "tri_i200");
      sample(897, 2'd3, 2'd0, 8'd255, "sq_i127");
      goto(898);  chk("sq_i128", {24'd0, wave_out}, 32'd0);
      sample(970, 2'd2, 2'd0, 8'd200, "saw_i200");
      sample(1036, 2'd3, 2'd1, 8'd191, "sq_hi_att1");
      sample(1156, 2'd3, 2'd1, 8'd64, "sq_lo_att1");
      sample(1166, 2'd3, 2'd3, 8'd112, "sq_lo_att3");
      sample(1292, 2'd3, 2'd3, 8'd143, "sq_hi_att3");
      sample(1474, 2'd0, 2'd2, 8'd96, "sine_i192_att2");
      goto(1536);
      atten     = 2'd0;
      phase_off = 8'd64;
      goto(1538); chk("poff64_acc0", {24'd0, wave_out}, 32'd255);
      phase_off = 8'd0;
      goto(1636);
      sync = 1'b1;
      goto(1637);
      sync = 1'b0;
                  chk("sync_inflight99", {24'd0, wave_out}, 32'd211);
                  chk("sync_no_tick", {31'd0, cycle_tick}, 32'd0);
      goto(1638); chk("sync_inflight100", {24'd0, wave_out}, 32'd209);
      goto(1639); chk("sync_idx0", {24'd0, wave_out}, 32'd128);
      goto(1640); chk("sync_idx1", {24'd0, wave_out}, 32'd131);
      goto(1892);
      sync = 1'b1;
      goto(1893);
      sync = 1'b0;
                  chk("sync_wrap_tick", {31'd0, cycle_tick}, 32'd0);
      goto(1900);
      ena = 1'b0;
      goto(1901);
      ena = 1'b1;
      goto(1902); chk("ena_s7_wave", {24'd0, wave_out}, 32'd150);
                  chk("ena_s7_valid", {31'd0, out_valid}, 32'd1);
      goto(1903); chk("ena_hold_wave", {24'd0, wave_out}, 32'd150);
                  chk("ena_hold_valid", {31'd0, out_valid}, 32'd0);
      goto(1904); chk("ena_s8_wave", {24'd0, wave_out}, 32'd153);
                  chk("ena_s8_valid", {31'd0, out_valid}, 32'd1);
      goto(1910);
      reset = 1'b1;
      goto(1911); chk("midrst_wave", {24'd0, wave_out}, 32'h80);
                  chk("midrst_valid", {31'd0, out_valid}, 32'd0);
                  chk("midrst_tick", {31'd0, cycle_tick}, 32'd0);
      reset     = 1'b0;
      freq_word = '0;
      phase_off = 8'd64;
      goto(1916); chk("f0_a", {24'd0, wave_out}, 32'd255);
                  chk("f0_valid", {31'd0, out_valid}, 32'd1);
      goto(1930); chk("f0_b", {24'd0, wave_out}, 32'd255);
      goto(1960); chk("f0_c", {24'd0, wave_out}, 32'd255);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
